// File: rtl/rgb565_pixel_assembler_pkg.sv
// Shared types and constants for the RGB565 pixel assembler.
// Camera bytes arrive high byte first; two bytes make one pixel.
package rgb565_pixel_assembler_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VS = 3'd1,
    S_VBLANK  = 3'd2,
    S_ACTIVE  = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_SINGLE = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_LINE_ERR = 1;
  localparam int STAT_X_OVF    = 2;
  localparam int STAT_FC_LSB   = 24;
  localparam int FC_W          = 8;

  localparam int BYTE_W = 8;
  localparam int R_W    = 5;
  localparam int G_W    = 6;
  localparam int B_W    = 5;
  localparam int PIX_W  = R_W + G_W + B_W;

endpackage

// File: rtl/rgb565_pixel_assembler_sync_edge_detect.sv
// One-cycle-delayed copy of a clk-synchronous level.
// Rise/fall pulses compare the live level against the copy.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;

  // previous-cycle copy of the level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig;
    end
  end

  assign rise = sig & ~sig_d;
  assign fall = ~sig & sig_d;

endmodule

// File: rtl/rgb565_pixel_assembler.sv
// Frames the camera byte stream and assembles RGB565 pixels
// with x/y coordinates, frame/line markers and capture control.
module rgb565_pixel_assembler
  import rgb565_pixel_assembler_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_PIXEL_DATA_WIDTH = 16,
  parameter int C_X_WIDTH          = 10,
  parameter int C_Y_WIDTH          = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    cam_data,
  input  logic                          cam_sample,
  input  logic                          cam_href,
  input  logic                          cam_vsync,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] register_control,
  output logic [C_S_AXI_DATA_WIDTH-1:0] register_status,
  output logic [C_PIXEL_DATA_WIDTH-1:0] data_out,
  output logic                          pixel_valid,
  output logic [C_X_WIDTH-1:0]          pixel_x,
  output logic [C_Y_WIDTH-1:0]          pixel_y,
  output logic                          frame_start,
  output logic                          line_end,
  output logic                          frame_done
);

  localparam logic [C_X_WIDTH-1:0] X_MAX = '1;
  localparam logic [C_Y_WIDTH-1:0] Y_MAX = '1;

  state_t               state;
  logic                 phase;
  logic [BYTE_W-1:0]    hi_byte;
  logic [C_X_WIDTH-1:0] x_cnt;
  logic [C_Y_WIDTH-1:0] y_cnt;
  logic [FC_W-1:0]      frame_count;
  logic                 line_error;
  logic                 x_overflow;
  logic                 busy;

  logic enable;
  logic single_frame;
  logic clear_status;
  logic href_rise;
  logic href_fall;
  logic vs_rise;
  logic vs_fall;
  logic take_byte;

  logic unused_ctrl;

  assign enable       = register_control[CTRL_ENABLE];
  assign single_frame = register_control[CTRL_SINGLE];
  assign clear_status = register_control[CTRL_CLEAR];
  assign unused_ctrl  = &{1'b0, register_control, href_rise};

  assign take_byte = cam_sample & cam_href;
  assign busy      = (state == S_ACTIVE);

  sync_edge_detect u_href_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (cam_href),
    .rise (href_rise),
    .fall (href_fall)
  );

  sync_edge_detect u_vsync_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (cam_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  // capture FSM, byte assembly, counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= 1'b0;
      hi_byte     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      frame_count <= '0;
      line_error  <= 1'b0;
      x_overflow  <= 1'b0;
      data_out    <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_done  <= 1'b0;

      // later set assignments in this block override the clear
      if (clear_status) begin
        line_error <= 1'b0;
        x_overflow <= 1'b0;
      end

      if (!enable) begin
        state <= S_IDLE;
        phase <= 1'b0;
        x_cnt <= '0;
        y_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state <= S_WAIT_VS;
          end
          S_WAIT_VS: begin
            if (cam_vsync) begin
              state <= S_VBLANK;
            end
          end
          S_VBLANK: begin
            if (vs_fall) begin
              state       <= S_ACTIVE;
              frame_start <= 1'b1;
              x_cnt       <= '0;
              y_cnt       <= '0;
              phase       <= 1'b0;
            end
          end
          S_ACTIVE: begin
            if (vs_rise) begin
              if (phase) begin
                line_error <= 1'b1;
              end
              phase       <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 1'b1;
              state       <= single_frame ? S_HOLD : S_VBLANK;
            end else if (href_fall) begin
              if (phase) begin
                line_error <= 1'b1;
              end
              phase <= 1'b0;
              if (x_cnt != '0) begin
                line_end <= 1'b1;
                x_cnt    <= '0;
                if (y_cnt == Y_MAX) begin
                  x_overflow <= 1'b1;
                end else begin
                  y_cnt <= y_cnt + 1'b1;
                end
              end
            end else if (take_byte) begin
              if (!phase) begin
                hi_byte <= cam_data;
                phase   <= 1'b1;
              end else begin
                data_out    <= {hi_byte, cam_data};
                pixel_valid <= 1'b1;
                pixel_x     <= x_cnt;
                pixel_y     <= y_cnt;
                phase       <= 1'b0;
                if (x_cnt == X_MAX) begin
                  x_overflow <= 1'b1;
                end else begin
                  x_cnt <= x_cnt + 1'b1;
                end
              end
            end
          end
          S_HOLD: begin
            state <= S_HOLD;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // status word assembled from live state
  always_comb begin
    register_status = '0;
    register_status[STAT_FC_LSB +: FC_W] = frame_count;
    register_status[STAT_X_OVF]          = x_overflow;
    register_status[STAT_LINE_ERR]       = line_error;
    register_status[STAT_BUSY]           = busy;
  end

endmodule

// File: tb/tb_rgb565_pixel_assembler.sv
// Bench for rgb565_pixel_assembler: table-driven lines,
// random bytes against a queue model, directed corner cases.
module tb_rgb565_pixel_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cam_data = '0;
  logic        cam_sample = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_vsync = 1'b0;
  logic [31:0] register_control = '0;

  logic [31:0] register_status;
  logic [15:0] data_out;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        frame_start;
  logic        line_end;
  logic        frame_done;

  logic [31:0] st2;
  logic [15:0] do2;
  logic        pv2;
  logic [1:0]  px2;
  logic [8:0]  py2;
  logic        fs2;
  logic        le2;
  logic        fd2;

  rgb565_pixel_assembler dut (
    .clk              (clk),
    .rst              (rst),
    .cam_data         (cam_data),
    .cam_sample       (cam_sample),
    .cam_href         (cam_href),
    .cam_vsync        (cam_vsync),
    .register_control (register_control),
    .register_status  (register_status),
    .data_out         (data_out),
    .pixel_valid      (pixel_valid),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .frame_start      (frame_start),
    .line_end         (line_end),
    .frame_done       (frame_done)
  );

  rgb565_pixel_assembler #(.C_X_WIDTH(2)) dut2 (
    .clk              (clk),
    .rst              (rst),
    .cam_data         (cam_data),
    .cam_sample       (cam_sample),
    .cam_href         (cam_href),
    .cam_vsync        (cam_vsync),
    .register_control (register_control),
    .register_status  (st2),
    .data_out         (do2),
    .pixel_valid      (pv2),
    .pixel_x          (px2),
    .pixel_y          (py2),
    .frame_start      (fs2),
    .line_end         (le2),
    .frame_done       (fd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
  } pix_t;

  typedef struct {
    int nbytes;
    bit err;
    bit lend;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int n_pix = 0;
  int n_le = 0;
  int n_fs = 0;
  int n_fd = 0;

  pix_t exp_q[$];
  int   q2[$];
  bit   rec2 = 1'b0;

  int         mx = 0;
  int         my = 0;
  int         mphase = 0;
  logic [7:0] mhi = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  pix_t mon_e;

  // observe outputs away from the active edge
  always @(negedge clk) begin
    if (pixel_valid) begin
      n_pix++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pixel: got %0h at (%0d,%0d) expected none",
                 data_out, pixel_x, pixel_y);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel", {data_out, pixel_x, pixel_y},
            {mon_e.d, mon_e.x, mon_e.y});
      end
    end
    if (line_end)    n_le++;
    if (frame_start) n_fs++;
    if (frame_done)  n_fd++;
    if (pv2 && rec2) q2.push_back(int'(px2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (mphase == 0) begin
      mhi    = b;
      mphase = 1;
    end else begin
      exp_q.push_back('{{mhi, b}, 10'(mx), 9'(my)});
      mx++;
      mphase = 0;
    end
  endtask

  task automatic model_line_end();
    if (mx != 0) my++;
    mx     = 0;
    mphase = 0;
  endtask

  task automatic strobe(input logic [7:0] b);
    cam_data   = b;
    cam_sample = 1'b1;
    step();
    cam_sample = 1'b0;
    step();
  endtask

  task automatic send_line(input int nbytes, input bit pat,
                           input bit use_model);
    logic [7:0] b;
    cam_href = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      if (pat) begin
        case (k % 4)
          0: b = 8'hF8;
          1: b = 8'h00;
          2: b = 8'h07;
          default: b = 8'hE0;
        endcase
      end else begin
        b = 8'($urandom);
        if (k > 0) repeat ($urandom_range(0, 2)) step();
      end
      if (use_model) model_byte(b);
      strobe(b);
    end
    cam_href = 1'b0;
    step();
    step();
    if (use_model) model_line_end();
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1;
    repeat (3) step();
    cam_vsync = 1'b0;
    repeat (2) step();
    mx     = 0;
    my     = 0;
    mphase = 0;
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (3) step();
  endtask

  task automatic pulse_clear(input logic [31:0] base);
    register_control = base | 32'h4;
    step();
    register_control = base;
  endtask

  vec_t tbl[8];
  int   exp2[6];
  int   le0;
  int   pix0;
  int   fd0;

  initial begin
    tbl[0] = '{8, 1'b0, 1'b1};
    tbl[1] = '{2, 1'b0, 1'b1};
    tbl[2] = '{3, 1'b1, 1'b1};
    tbl[3] = '{0, 1'b0, 1'b0};
    tbl[4] = '{1, 1'b1, 1'b0};
    tbl[5] = '{20, 1'b0, 1'b1};
    tbl[6] = '{5, 1'b1, 1'b1};
    tbl[7] = '{14, 1'b0, 1'b1};
    exp2   = '{0, 1, 2, 3, 3, 3};

    repeat (2) step();
    chk("reset_outputs",
        {data_out, pixel_valid, pixel_x, pixel_y,
         frame_start, line_end, frame_done}, '0);
    chk("reset_status", register_status, 32'h0);
    rst = 1'b0;
    step();

    // two lines of four pixels with fixed colours
    register_control = 32'h1;
    repeat (2) step();
    frame_begin();
    send_line(8, 1'b1, 1'b1);
    chk("busy_active", register_status[0], 1);
    send_line(8, 1'b1, 1'b1);
    chk("frame_start_count", n_fs, 1);
    chk("line_end_count", n_le, 2);
    chk("pixel_count", n_pix, 8);
    frame_end();
    chk("frame_done_count", n_fd, 1);
    chk("frame_count_1", register_status[31:24], 1);
    chk("busy_vblank", register_status[0], 0);

    // table of lines with random bytes
    frame_begin();
    for (int i = 0; i < 8; i++) begin
      cam_data   = 8'($urandom);
      cam_sample = 1'b1;
      step();
      cam_sample = 1'b0;
      step();
      le0  = n_le;
      pix0 = n_pix;
      send_line(tbl[i].nbytes, 1'b0, 1'b1);
      chk("tbl_line_end", n_le - le0, tbl[i].lend);
      chk("tbl_pixels", n_pix - pix0, tbl[i].nbytes / 2);
      chk("tbl_line_err", register_status[1], tbl[i].err);
      if (tbl[i].err) begin
        pulse_clear(32'h1);
        chk("tbl_err_cleared", register_status[1], 0);
      end
    end
    frame_end();
    chk("frame_count_2", register_status[31:24], 2);

    // x saturation on the narrow instance
    frame_begin();
    pulse_clear(32'h1);
    chk("ovf_cleared", st2[2], 0);
    rec2 = 1'b1;
    send_line(12, 1'b0, 1'b1);
    rec2 = 1'b0;
    chk("ovf_set", st2[2], 1);
    chk("ovf_count", q2.size(), 6);
    if (q2.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("ovf_pixel_x", q2[i], exp2[i]);
    end
    frame_end();

    // single frame then hold
    register_control = 32'h3;
    frame_begin();
    send_line(4, 1'b0, 1'b1);
    frame_end();
    chk("single_count", register_status[31:24], 4);
    frame_begin();
    send_line(6, 1'b0, 1'b0);
    frame_end();
    chk("hold_count", register_status[31:24], 4);
    chk("hold_busy", register_status[0], 0);
    register_control = 32'h0;
    step();

    // enable mid-frame skips the partial frame
    cam_vsync = 1'b0;
    step();
    register_control = 32'h1;
    repeat (2) step();
    pix0 = n_pix;
    send_line(6, 1'b0, 1'b0);
    chk("partial_skipped", n_pix - pix0, 0);
    frame_begin();
    send_line(4, 1'b0, 1'b1);
    frame_end();
    chk("count_after_skip", register_status[31:24], 5);

    // enable drop coincident with a low byte
    frame_begin();
    fd0 = n_fd;
    cam_href = 1'b1;
    strobe(8'hAB);
    cam_data         = 8'hCD;
    cam_sample       = 1'b1;
    register_control = 32'h0;
    step();
    cam_sample = 1'b0;
    cam_href   = 1'b0;
    chk("drop_no_pixel", pixel_valid, 0);
    chk("drop_idle", register_status[0], 0);
    cam_vsync = 1'b1;
    repeat (4) step();
    chk("drop_no_done", n_fd - fd0, 0);
    chk("drop_count", register_status[31:24], 5);

    // asynchronous reset mid-line
    register_control = 32'h1;
    repeat (2) step();
    frame_begin();
    cam_href = 1'b1;
    strobe(8'h12);
    cam_data   = 8'h34;
    cam_sample = 1'b1;
    step();
    chk("pre_rst_pixel", {pixel_valid, data_out}, {1'b1, 16'h1234});
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs",
        {data_out, pixel_valid, pixel_x, pixel_y,
         frame_start, line_end, frame_done}, '0);
    chk("async_rst_status", register_status, 32'h0);
    cam_sample = 1'b0;
    cam_href   = 1'b0;
    step();
    rst = 1'b0;
    step();

    chk("model_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb565_pixel_assembler.md
Name: rgb565_pixel_assembler

Overview:
Upstream neighbour of the brightness/contrast pixel stage in the capture_video IP. Takes the camera's 8-bit byte stream, two bytes per RGB565 pixel with the high byte first, already synchronised to the system clock with a per-byte strobe. Tracks VSYNC/HREF framing and emits one 16-bit pixel per strobe pair, with x/y coordinates and frame/line markers. Supports continuous and single-frame capture under AXI register control.

Parameters:
C_S_AXI_DATA_WIDTH, 32, width of control/status register ports
C_PIXEL_DATA_WIDTH, 16, output pixel width (RGB565); fixed at 16
C_X_WIDTH, 10, pixel column counter width
C_Y_WIDTH, 9, line counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cam_data  in  8  camera byte, valid when cam_sample=1
cam_sample  in  1  one-cycle strobe per camera byte (PCLK edge, generated upstream)
cam_href  in  1  line-valid, synchronous to clk
cam_vsync  in  1  high during vertical blanking, synchronous to clk
register_control  in  C_S_AXI_DATA_WIDTH  bit0 capture_enable, bit1 single_frame, bit2 clear_status (level)
register_status  out  C_S_AXI_DATA_WIDTH  [31:24] frame_count, [2] x_overflow, [1] line_error, [0] busy
data_out  out  C_PIXEL_DATA_WIDTH  assembled pixel {high byte, low byte}
pixel_valid  out  1  one-cycle pixel qualifier
pixel_x  out  C_X_WIDTH  column of data_out
pixel_y  out  C_Y_WIDTH  line of data_out
frame_start  out  1  one-cycle pulse, first active line begins
line_end  out  1  one-cycle pulse after last pixel of a line
frame_done  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset: all outputs 0; FSM in S_IDLE; byte phase 0; x=0, y=0; frame_count=0; flags cleared.
- Edges come from a one-cycle-delayed copy of href/vsync. The delayed copies reset to 0.
- FSM states:
  - S_IDLE: enable=1 -> S_WAIT_VS.
  - S_WAIT_VS: vsync=1 -> S_VBLANK. Skips any partial frame.
  - S_VBLANK: vsync falling edge -> S_ACTIVE; frame_start pulses the next cycle; x=0, y=0, phase=0.
  - S_ACTIVE: vsync rising edge -> frame_done pulse and frame_count+1 (wraps 255->0). Then single_frame=1 -> S_HOLD, else -> S_VBLANK.
  - S_HOLD: stays until enable=0, then -> S_IDLE.
- enable=0 in any state -> S_IDLE the next cycle.
  - A pixel completing in that same cycle is dropped; no frame_done is issued.
  - Counters and phase are cleared.
- busy=1 in S_ACTIVE only.
- Byte assembly, S_ACTIVE only:
  - cam_sample=1 & cam_href=1 & phase=0: latch high byte, phase<=1.
  - cam_sample=1 & cam_href=1 & phase=1: data_out<={hi,cam_data}, pixel_valid<=1, pixel_x<=x, pixel_y<=y; then x+1, phase<=0.
  - Latency: pixel_valid is registered, one cycle after the low-byte strobe.
  - cam_sample with href=0 is ignored.
  - A strobe in the cycle href rises counts, because the current href is used.
- href falling edge:
  - If phase=1: line_error<=1 (sticky) and the partial byte is discarded.
  - phase<=0.
  - If x!=0: line_end pulses, y+1, x<=0.
  - If x=0: no line_end; y is unchanged.
- vsync rising edge mid-line: behaves as an href fall (error check, phase clear), but with no line_end; then frame_done.
- x saturation: at all-ones, further pixels still output with pixel_x held at max; x_overflow<=1 (sticky). y saturates the same way and sets the same flag.
- clear_status=1: clears line_error and x_overflow. If a set event occurs in the same cycle, the set wins. clear_status does not clear frame_count.
- frame_start, line_end, frame_done and pixel_valid are single-cycle registered pulses, never held.

Decomposition:
- Shared package: state encoding (S_IDLE, S_WAIT_VS, S_VBLANK, S_ACTIVE, S_HOLD); control bit positions (CTRL_ENABLE=0, CTRL_SINGLE=1, CTRL_CLEAR=2); status bit positions; RGB565 field widths.
- One natural sub-module: sync_edge_detect (registered rise/fall pulses for href and vsync), instantiated twice.

Test Plan:
- Enable, vsync 1->0, 2 lines of 4 pixels (bytes F8,00,07,E0,...) -> frame_start once; pixels F800, 07E0 at (0,0),(1,0)...; line_end twice; y ends at 2.
- Vsync rises after frame -> frame_done 1 cycle, frame_count=1. With single_frame=1, frame_count stays 1 through the next frame until enable toggles.
- Enable asserted mid-active-frame (vsync=0) -> no pixels until vsync rises, then falls; first pixel at (0,0).
- href falls after 3 bytes -> 1 pixel output, line_error=1, next line starts x=0. clear_status -> line_error=0.
- C_X_WIDTH=2, 6 pixels on a line -> pixel_x sequence 0,1,2,3,3,3; x_overflow=1.
- enable=0 coincident with low-byte strobe -> no pixel_valid, no frame_done, state S_IDLE next cycle. Async rst mid-line -> all outputs 0 immediately.
